// File: rtl/sound_pkg.sv
// Shared definitions for the snake-game sound output path.
package sound_pkg;

    localparam logic [2:0] ATT_MUTE = 3'd4;

    typedef enum logic {
        STEADY = 1'b0,
        RAMP   = 1'b1
    } ramp_state_t;

    // Attenuation the ramp is heading for: mute forces silence, otherwise 3 - volume.
    function automatic logic [2:0] target_att(input logic [1:0] volume, input logic mute);
        if (mute) begin
            return ATT_MUTE;
        end
        return 3'd3 - {1'b0, volume};
    endfunction

endpackage

// File: rtl/att_ramp.sv
// Anti-pop attenuation ramp: moves att one step per PWM period toward the
// volume/mute target, starting silent after reset.
module att_ramp
    import sound_pkg::*;
(
    input  logic       clk,
    input  logic       nRst,
    input  logic       boundary,
    input  logic [1:0] volume_i,
    input  logic       mute_i,
    output logic [2:0] att_next
);

    logic [2:0]  att;
    logic [2:0]  tgt;
    ramp_state_t state;
    ramp_state_t state_next;

    assign tgt = target_att(volume_i, mute_i);

    // att_next is the post-step value so the duty latch can use it on the same edge.
    always_comb begin
        att_next   = att;
        state_next = state;
        if (boundary) begin
            if (att < tgt) begin
                att_next = att + 3'd1;
            end else if (att > tgt) begin
                att_next = att - 3'd1;
            end
            state_next = (att_next == tgt) ? STEADY : RAMP;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            att   <= ATT_MUTE;
            state <= STEADY;
        end else begin
            att   <= att_next;
            state <= state_next;
        end
    end

endmodule

// File: rtl/pwm_audio_out.sv
// Single-pin PWM audio output: free-running period counter, per-period sample
// and attenuation latch, registered compare output.
module pwm_audio_out
    import sound_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic [N-1:0] sample_i,
    input  logic [1:0]   volume_i,
    input  logic         mute_i,
    output logic         pwm_o,
    output logic         period_start_o
);

    logic [N-1:0] cnt;
    logic [N-1:0] duty;
    logic         boundary;
    logic [2:0]   att_next;

    assign boundary = (cnt == '1);

    att_ramp u_ramp (
        .clk      (clk),
        .nRst     (nRst),
        .boundary (boundary),
        .volume_i (volume_i),
        .mute_i   (mute_i),
        .att_next (att_next)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt            <= '0;
            duty           <= '0;
            pwm_o          <= 1'b0;
            period_start_o <= 1'b0;
        end else begin
            cnt            <= cnt + 1'b1;
            period_start_o <= boundary;
            // cnt < duty can never hold at cnt == 2^N-1, so the pin is never 100 % high.
            pwm_o          <= (cnt < duty);
            if (boundary) begin
                duty <= (att_next == ATT_MUTE) ? '0 : (sample_i >> att_next);
            end
        end
    end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Scoreboard bench for pwm_audio_out: stimulus queues the expected high count
// of each PWM period, a negedge monitor measures periods and compares.
module tb_pwm_audio_out;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic [N-1:0] sample_i = 8'h80;
    logic [1:0]   volume_i = 2'd3;
    logic         mute_i = 1'b0;
    logic         pwm_o;
    logic         period_start_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int    exp_q[$];
    string name_q[$];
    int    hi_cnt = 0;
    int    len_cnt = 0;

    always #5 clk = ~clk;

    pwm_audio_out #(.N(N)) dut (
        .clk            (clk),
        .nRst           (nRst),
        .sample_i       (sample_i),
        .volume_i       (volume_i),
        .mute_i         (mute_i),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o)
    );

    task automatic close_window();
        int    e;
        string nm;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_period: hi=%0d len=%0d, no expected entry queued", hi_cnt, len_cnt);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (hi_cnt != e) begin
                errors++;
                $display("FAIL %s hi_count: got %0d expected %0d", nm, hi_cnt, e);
            end
            checks++;
            if (len_cnt != 256) begin
                errors++;
                $display("FAIL %s period_len: got %0d expected 256", nm, len_cnt);
            end
        end
    endtask

    // Monitor: a window runs from one period_start pulse up to the next.
    always @(negedge clk) begin
        if (!nRst) begin
            hi_cnt  = 0;
            len_cnt = 0;
        end else begin
            if (period_start_o) begin
                close_window();
                hi_cnt  = 0;
                len_cnt = 0;
            end
            hi_cnt  = hi_cnt + int'(pwm_o);
            len_cnt = len_cnt + 1;
        end
    end

    task automatic push(input int hi, input string nm);
        exp_q.push_back(hi);
        name_q.push_back(nm);
    endtask

    task automatic wait_pulse();
        bit seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (nRst && period_start_o) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL period_start_timeout: got no pulse expected one within 600 cycles");
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_pwm", pwm_o, 1'b0);
        check_bit("reset_period_start", period_start_o, 1'b0);
        nRst = 1'b1;

        // Fade-in with 0x80 at full volume.
        push(0, "fade_att4");
        wait_pulse(); push(16,  "fade_att3");
        wait_pulse(); push(32,  "fade_att2");
        wait_pulse(); push(64,  "fade_att1");
        wait_pulse(); push(128, "fade_att0");
        wait_pulse(); push(128, "steady_att0");
        sample_i = 8'hFF;

        // Full-scale sample at att 0.
        wait_pulse(); push(255, "full_ff");
        wait_pulse(); push(255, "full_ff_hold");
        mute_i = 1'b1;

        // Mute ramp down, then hold silent with 0xFF still applied.
        wait_pulse(); push(127, "mute_att1");
        wait_pulse(); push(63,  "mute_att2");
        wait_pulse(); push(31,  "mute_att3");
        wait_pulse(); push(0,   "mute_att4");
        wait_pulse(); push(0,   "muted_hold");
        mute_i = 1'b0;

        wait_pulse(); push(31,  "unmute_att3");
        wait_pulse(); push(63,  "unmute_att2");
        wait_pulse(); push(127, "unmute_att1");
        wait_pulse(); push(255, "unmute_att0");

        // Mid-period changes that revert before the boundary leave nothing behind.
        wait_pulse(); push(255, "glitch_period");
        repeat (100) @(negedge clk);
        sample_i = 8'h40; volume_i = 2'd1;
        repeat (50) @(negedge clk);
        sample_i = 8'hFF; volume_i = 2'd3;

        // Mid-period change that persists applies only from the next period.
        wait_pulse(); push(255, "late_change_period");
        repeat (100) @(negedge clk);
        sample_i = 8'h40; volume_i = 2'd2;
        wait_pulse(); push(32, "vol2_att1");
        sample_i = 8'h80; volume_i = 2'd1;
        wait_pulse(); push(32, "vol1_att2");
        mute_i = 1'b1;

        // Mute for one boundary from att 2: 2->3->2->1->0.
        wait_pulse(); push(16, "blip_att3");
        mute_i = 1'b0; volume_i = 2'd3;
        wait_pulse(); push(32,  "blip_att2");
        wait_pulse(); push(64,  "blip_att1");
        wait_pulse(); push(128, "blip_att0");

        // Reset mid-period; the interrupted period is not scored.
        wait_pulse();
        repeat (100) @(negedge clk);
        check_bit("pwm_high_before_reset", pwm_o, 1'b1);
        #2 nRst = 1'b0;
        #1;
        check_bit("async_reset_pwm", pwm_o, 1'b0);
        check_bit("async_reset_period_start", period_start_o, 1'b0);
        repeat (5) @(posedge clk);
        #1 nRst = 1'b1;
        push(0, "refade_att4");
        wait_pulse(); push(16,  "refade_att3");
        wait_pulse(); push(32,  "refade_att2");
        wait_pulse(); push(64,  "refade_att1");
        wait_pulse(); push(128, "refade_att0");
        wait_pulse();

        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
